// File: rtl/tlc_pkg.sv
// Shared types for the traffic sequencer: state/phase encodings, lamp codes, lamp decode.
// TRAFFIC_WALK_EN adds the all-red pedestrian WALK state.
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_MG   = 3'd0,
        ST_MGX  = 3'd1,
        ST_MY   = 3'd2,
`ifdef TRAFFIC_WALK_EN
        ST_WALK = 3'd3,
`endif
        ST_SG   = 3'd4,
        ST_SGX  = 3'd5,
        ST_SY   = 3'd6
    } state_t;

    // START exists only out of reset: the first edge afterwards performs the issue.
    typedef enum logic [1:0] {
        PH_START = 2'd0,
        PH_ISSUE = 2'd1,
        PH_WAIT0 = 2'd2,
        PH_WAIT  = 2'd3
    } phase_t;

    localparam logic [2:0] LT_R = 3'b100;
    localparam logic [2:0] LT_Y = 3'b010;
    localparam logic [2:0] LT_G = 3'b001;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
    } lamps_t;

    function automatic lamps_t lamps_of(input state_t s);
        lamps_t l;
        l.main = LT_R;
        l.side = LT_R;
        l.walk = 1'b0;
        case (s)
            ST_MG, ST_MGX: l.main = LT_G;
            ST_MY:         l.main = LT_Y;
            ST_SG, ST_SGX: l.side = LT_G;
            ST_SY:         l.side = LT_Y;
`ifdef TRAFFIC_WALK_EN
            ST_WALK:       l.walk = 1'b1;
`endif
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for an asynchronous level input, cleared by async active-low reset.
module input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// Two-street traffic light sequencer driving an external interval timer.
// Optional pedestrian WALK phase when TRAFFIC_WALK_EN is defined.
module traffic_sequencer
    import tlc_pkg::*;
#(
    parameter logic [3:0] T_BASE = 4'd6,
    parameter logic [3:0] T_EXT  = 4'd3,
    parameter logic [3:0] T_YEL  = 4'd2,
    parameter logic [3:0] T_WALK = 4'd3
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       sensor,
    input  logic       walk_req,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic       walk
);

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    lamps_t     lamps_d;
    logic [3:0] value_d;
    logic       start_d;
    logic       sensor_s;

    function automatic logic [3:0] interval_of(input state_t s);
        case (s)
            ST_MG, ST_SG:   return T_BASE;
            ST_MGX, ST_SGX: return T_EXT;
            ST_MY, ST_SY:   return T_YEL;
            default:        return T_WALK;
        endcase
    endfunction

    input_sync u_sync_sensor (
        .clk   (clk),
        .rst_n (Reset_n),
        .d     (sensor),
        .q     (sensor_s)
    );

`ifdef TRAFFIC_WALK_EN
    logic walk_s;
    logic req_q, req_d;

    input_sync u_sync_walk (
        .clk   (clk),
        .rst_n (Reset_n),
        .d     (walk_req),
        .q     (walk_s)
    );
`else
    logic unused_walk_req;
    assign unused_walk_req = walk_req;
`endif

    // State, phase and all lamp/timer outputs are registered together.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_MG;
            phase_q     <= PH_START;
            start_timer <= 1'b0;
            value       <= T_BASE;
            main_lt     <= LT_G;
            side_lt     <= LT_R;
            walk        <= 1'b0;
`ifdef TRAFFIC_WALK_EN
            req_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            start_timer <= start_d;
            value       <= value_d;
            main_lt     <= lamps_d.main;
            side_lt     <= lamps_d.side;
            walk        <= lamps_d.walk;
`ifdef TRAFFIC_WALK_EN
            req_q       <= req_d;
`endif
        end
    end

    // Next state; expired only counts in PH_WAIT, so a stale pulse cannot end a state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
`ifdef TRAFFIC_WALK_EN
        req_d   = req_q | walk_s;
`endif
        case (phase_q)
            PH_START: phase_d = PH_ISSUE;
            PH_ISSUE: phase_d = PH_WAIT0;
            PH_WAIT0: phase_d = PH_WAIT;
            PH_WAIT: begin
                if (expired) begin
                    phase_d = PH_ISSUE;
                    case (state_q)
                        ST_MG:   state_d = sensor_s ? ST_MGX : ST_MY;
                        ST_MGX:  state_d = ST_MY;
`ifdef TRAFFIC_WALK_EN
                        ST_MY: begin
                            if (req_q || walk_s) begin
                                state_d = ST_WALK;
                                req_d   = 1'b0;
                            end else begin
                                state_d = ST_SG;
                            end
                        end
                        ST_WALK: state_d = ST_SG;
`else
                        ST_MY:   state_d = ST_SG;
`endif
                        ST_SG:   state_d = sensor_s ? ST_SGX : ST_SY;
                        ST_SGX:  state_d = ST_SY;
                        ST_SY:   state_d = ST_MG;
                        default: state_d = ST_MG;
                    endcase
                end
            end
            default: phase_d = PH_START;
        endcase

        start_d = (phase_d == PH_ISSUE);
        value_d = interval_of(state_d);
        lamps_d = lamps_of(state_d);
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer; outputs packed as {value, main_lt, side_lt, walk}.
module tb_traffic_sequencer;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       sensor = 1'b0;
    logic       walk_req = 1'b0;
    logic       expired = 1'b0;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_lt;
    logic [2:0] side_lt;
    logic       walk;

    int passed = 0;
    int total  = 0;

    localparam logic [10:0] V_MG   = {4'd6, 3'b001, 3'b100, 1'b0};
    localparam logic [10:0] V_MGX  = {4'd3, 3'b001, 3'b100, 1'b0};
    localparam logic [10:0] V_MY   = {4'd2, 3'b010, 3'b100, 1'b0};
    localparam logic [10:0] V_WALK = {4'd3, 3'b100, 3'b100, 1'b1};
    localparam logic [10:0] V_SG   = {4'd6, 3'b100, 3'b001, 1'b0};
    localparam logic [10:0] V_SGX  = {4'd3, 3'b100, 3'b001, 1'b0};
    localparam logic [10:0] V_SY   = {4'd2, 3'b100, 3'b010, 1'b0};

    traffic_sequencer dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .sensor      (sensor),
        .walk_req    (walk_req),
        .expired     (expired),
        .start_timer (start_timer),
        .value       (value),
        .main_lt     (main_lt),
        .side_lt     (side_lt),
        .walk        (walk)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        Reset_n  = 1'b0;
        sensor   = s;
        expired  = 1'b0;
        walk_req = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (start_timer === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Timer model: expired pulses for one cycle, two cycles after the start pulse.
    task automatic pulse_expiry();
        tick();
        tick();
        expired = 1'b1;
        tick();
        expired = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        tick();
        total++;
        if ({start_timer, value, main_lt, side_lt, walk} !== {1'b0, V_MG})
            $display("FAIL reset_values got %h want %h",
                     {start_timer, value, main_lt, side_lt, walk}, {1'b0, V_MG});
        else passed++;
        Reset_n = 1'b1;
        #1;
        total++;
        if (start_timer !== 1'b0) $display("FAIL release_no_start got %b want 0", start_timer);
        else passed++;
        tick();
        total++;
        if ({start_timer, value, main_lt, side_lt, walk} !== {1'b1, V_MG})
            $display("FAIL first_issue got %h want %h",
                     {start_timer, value, main_lt, side_lt, walk}, {1'b1, V_MG});
        else passed++;
        tick();
        total++;
        if (start_timer !== 1'b0) $display("FAIL single_pulse got %b want 0", start_timer);
        else passed++;
    endtask

    task automatic test_basic();
        logic [10:0] seq [5] = '{V_MG, V_MY, V_SG, V_SY, V_MG};
        bit ok;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_start(ok);
            total++;
            if (!ok) $display("FAIL basic[%0d] start_timer timeout got 0 want 1", i);
            else if ({value, main_lt, side_lt, walk} !== seq[i])
                $display("FAIL basic[%0d] got %h want %h", i, {value, main_lt, side_lt, walk}, seq[i]);
            else passed++;
            pulse_expiry();
        end
    endtask

    task automatic test_sensor();
        logic [10:0] seq [7] = '{V_MG, V_MGX, V_MY, V_SG, V_SGX, V_SY, V_MG};
        bit ok;
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) begin
            wait_start(ok);
            total++;
            if (!ok) $display("FAIL sensor[%0d] start_timer timeout got 0 want 1", i);
            else if ({value, main_lt, side_lt, walk} !== seq[i])
                $display("FAIL sensor[%0d] got %h want %h", i, {value, main_lt, side_lt, walk}, seq[i]);
            else passed++;
            pulse_expiry();
        end
        sensor = 1'b0;
    endtask

    task automatic test_expired_held();
        logic [10:0] seq [5] = '{V_MG, V_MY, V_SG, V_SY, V_MG};
        do_reset(1'b0);
        expired = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({start_timer, value, main_lt, side_lt, walk} !== {1'b1, seq[i]})
                $display("FAIL held[%0d] got %h want %h", i,
                         {start_timer, value, main_lt, side_lt, walk}, {1'b1, seq[i]});
            else passed++;
            for (int c = 0; c < 2; c++) begin
                tick();
                total++;
                if (start_timer !== 1'b0 || (main_lt[0] & side_lt[0]) !== 1'b0)
                    $display("FAIL held_wait[%0d.%0d] got start=%b main=%b side=%b want start=0, no double green",
                             i, c, start_timer, main_lt, side_lt);
                else passed++;
            end
            tick();
        end
        expired = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [10:0] seq [5] = '{V_MG, V_MGX, V_MY, V_SG, V_SGX};
        bit ok;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_start(ok);
            total++;
            if (!ok) $display("FAIL mid[%0d] start_timer timeout got 0 want 1", i);
            else if ({value, main_lt, side_lt, walk} !== seq[i])
                $display("FAIL mid[%0d] got %h want %h", i, {value, main_lt, side_lt, walk}, seq[i]);
            else passed++;
            if (i < 4) pulse_expiry();
        end
        tick();
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if ({start_timer, value, main_lt, side_lt, walk} !== {1'b0, V_MG})
            $display("FAIL mid_async_reset got %h want %h",
                     {start_timer, value, main_lt, side_lt, walk}, {1'b0, V_MG});
        else passed++;
        tick();
        sensor  = 1'b0;
        Reset_n = 1'b1;
        tick();
        total++;
        if ({start_timer, value, main_lt, side_lt, walk} !== {1'b1, V_MG})
            $display("FAIL mid_restart got %h want %h",
                     {start_timer, value, main_lt, side_lt, walk}, {1'b1, V_MG});
        else passed++;
    endtask

`ifdef TRAFFIC_WALK_EN
    task automatic test_walk();
        logic [10:0] seq [8] = '{V_MG, V_MY, V_WALK, V_SG, V_SY, V_MG, V_MY, V_SG};
        bit ok;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            wait_start(ok);
            total++;
            if (!ok) $display("FAIL walk[%0d] start_timer timeout got 0 want 1", i);
            else if ({value, main_lt, side_lt, walk} !== seq[i])
                $display("FAIL walk[%0d] got %h want %h", i, {value, main_lt, side_lt, walk}, seq[i]);
            else passed++;
            if (i == 0) begin
                walk_req = 1'b1;
                tick();
                walk_req = 1'b0;
                tick();
                expired = 1'b1;
                tick();
                expired = 1'b0;
            end else begin
                pulse_expiry();
            end
        end
    endtask
`else
    task automatic test_walk();
        logic [10:0] seq [4] = '{V_MG, V_MY, V_SG, V_SY};
        bit ok;
        do_reset(1'b0);
        walk_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(ok);
            total++;
            if (!ok) $display("FAIL walk_off[%0d] start_timer timeout got 0 want 1", i);
            else if ({value, main_lt, side_lt, walk} !== seq[i])
                $display("FAIL walk_off[%0d] got %h want %h", i, {value, main_lt, side_lt, walk}, seq[i]);
            else passed++;
            pulse_expiry();
        end
        walk_req = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_sensor();
        test_expired_held();
        test_reset_mid();
        test_walk();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
